// File: rtl/column_config_pkg.sv
// Shared definitions for the column configuration loader: FSM states, CRC-8
// polynomial and column geometry.
package column_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CRC8_POLY            = 8'h07;
  localparam int         CLEAR_CYCLES_DEFAULT = 2;
  localparam int         TILES_PER_COLUMN     = 16;
  localparam int         TILE_CONFIG_BITS     = 16;
  localparam int         COLUMN_CHAIN_LENGTH  = TILES_PER_COLUMN * TILE_CONFIG_BITS;

  // One MSB-first CRC-8 step: feedback is the top CRC bit xor the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/config_crc8.sv
// Bit-serial CRC-8 (init 0x00, no reflection, no final xor) over the bits
// shifted into the configuration chain.
module config_crc8
  import column_config_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit_in,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_crc <= 8'h00;
    end else if (i_enable) begin
      r_crc <= crc8_step(r_crc, i_bit_in);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/column_config_loader.sv
// Bit-serial loader for a column's daisy-chained configuration register.
// Optional trailing CRC-8 check word is enabled with COLUMN_CONFIG_CRC_EN.
//
// Word stream: a word transfers on a rising edge where o_word_ready and
// i_word_valid are both high; o_word_ready is high only in LOAD (and CHECK),
// and i_word_data is ignored at all other times.
module column_config_loader
  import column_config_pkg::*;
#(
  parameter int CHAIN_LENGTH = COLUMN_CHAIN_LENGTH,
  parameter int WORD_WIDTH   = 8,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEFAULT
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_word_data,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic                  o_chain_in,
  input  logic                  i_chain_out,
  output logic                  o_chain_enable,
  output logic                  o_chain_nreset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int BCW = $clog2(CHAIN_LENGTH + 1);
  localparam int WCW = $clog2(WORD_WIDTH + 1);
  localparam int CCW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LENGTH - 1);
  localparam logic [WCW-1:0] LAST_WBIT = WCW'(WORD_WIDTH - 1);
  localparam logic [CCW-1:0] LAST_CLR  = CCW'(CLEAR_CYCLES - 1);

  state_t                r_state, w_next;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt;
  logic [WCW-1:0]        r_wbit_cnt, w_wbit_cnt;
  logic [CCW-1:0]        r_clr_cnt, w_clr_cnt;
  logic [WORD_WIDTH-1:0] r_shreg, w_shreg;
  logic                  r_word_ready, r_chain_in, r_chain_enable, r_chain_nreset;
  logic                  r_busy, r_done, r_error;
  logic                  w_hs;

  assign w_hs = r_word_ready && i_word_valid;

`ifdef COLUMN_CONFIG_CRC_EN
  logic [7:0] w_crc;
  logic       w_crc_clear;

  assign w_crc_clear = i_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);

  // r_chain_in is exactly the bit the chain samples during each SHIFT cycle.
  config_crc8 u_crc (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_crc_clear),
    .i_enable (r_state == ST_SHIFT),
    .i_bit_in (r_chain_in),
    .o_crc    (w_crc)
  );
`endif

  always_comb begin
    w_next     = r_state;
    w_bit_cnt  = r_bit_cnt;
    w_wbit_cnt = r_wbit_cnt;
    w_clr_cnt  = r_clr_cnt;
    w_shreg    = r_shreg;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_next     = ST_CLEAR;
          w_bit_cnt  = '0;
          w_wbit_cnt = '0;
          w_clr_cnt  = '0;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == LAST_CLR) w_next = ST_LOAD;
        else                       w_clr_cnt = r_clr_cnt + 1'b1;
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_shreg    = i_word_data;
          w_wbit_cnt = '0;
          w_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shreg    = r_shreg >> 1;
        w_bit_cnt  = r_bit_cnt + 1'b1;
        w_wbit_cnt = r_wbit_cnt + 1'b1;
        // The chain was cleared, so any 1 emerging from it means a broken chain.
        if (i_chain_out) begin
          w_next = ST_ERROR;
        end else if (r_bit_cnt == LAST_BIT) begin
`ifdef COLUMN_CONFIG_CRC_EN
          w_next = ST_CHECK;
`else
          w_next = ST_DONE;
`endif
        end else if (r_wbit_cnt == LAST_WBIT) begin
          w_next = ST_LOAD;
        end
      end
`ifdef COLUMN_CONFIG_CRC_EN
      ST_CHECK: begin
        if (w_hs) w_next = (i_word_data[7:0] == w_crc) ? ST_DONE : ST_ERROR;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_wbit_cnt     <= '0;
      r_clr_cnt      <= '0;
      r_shreg        <= '0;
      r_word_ready   <= 1'b0;
      r_chain_in     <= 1'b0;
      r_chain_enable <= 1'b0;
      r_chain_nreset <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_bit_cnt      <= w_bit_cnt;
      r_wbit_cnt     <= w_wbit_cnt;
      r_clr_cnt      <= w_clr_cnt;
      r_shreg        <= w_shreg;
      r_word_ready   <= (w_next == ST_LOAD) || (w_next == ST_CHECK);
      r_chain_enable <= (w_next == ST_SHIFT);
      r_chain_in     <= (w_next == ST_SHIFT) && w_shreg[0];
      r_busy         <= (w_next == ST_CLEAR) || (w_next == ST_LOAD) ||
                        (w_next == ST_SHIFT) || (w_next == ST_CHECK);
      r_done         <= (w_next == ST_DONE);
      r_error        <= (w_next == ST_ERROR);
      case (w_next)
        ST_CLEAR, ST_ERROR: r_chain_nreset <= 1'b0;
        ST_IDLE:            r_chain_nreset <= r_chain_nreset;
        default:            r_chain_nreset <= 1'b1;
      endcase
    end
  end

  assign o_word_ready   = r_word_ready;
  assign o_chain_in     = r_chain_in;
  assign o_chain_enable = r_chain_enable;
  assign o_chain_nreset = r_chain_nreset;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_column_config_loader.sv
// Directed bench for column_config_loader (CHAIN_LENGTH=20, WORD_WIDTH=8);
// the CRC-word cases are built when COLUMN_CONFIG_CRC_EN is defined.
`timescale 1ns/1ps
module tb_column_config_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CC = 2;
`ifdef COLUMN_CONFIG_CRC_EN
  localparam int DONE_CYCLE = 27;
  localparam int N_WORDS    = 4;
`else
  localparam int DONE_CYCLE = 26;
  localparam int N_WORDS    = 3;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, wvalid, chain_out;
  logic [WW-1:0] wdata;
  logic          word_ready, chain_in, chain_enable, chain_nreset, busy, done, error;

  column_config_loader #(
    .CHAIN_LENGTH (CL),
    .WORD_WIDTH   (WW),
    .CLEAR_CYCLES (CC)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_word_data    (wdata),
    .i_word_valid   (wvalid),
    .o_word_ready   (word_ready),
    .o_chain_in     (chain_in),
    .i_chain_out    (chain_out),
    .o_chain_enable (chain_enable),
    .o_chain_nreset (chain_nreset),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // word source: presents words[hs_idx], advancing on each accepted handshake
  logic [WW-1:0] words [4];
  int            hs_idx;
  logic          hs_clear;

  always @(posedge clk) begin
    if (hs_clear)                  hs_idx <= 0;
    else if (word_ready && wvalid) hs_idx <= hs_idx + 1;
  end

  always_comb begin
    wdata = 8'h00;
    if (hs_idx < 4) wdata = words[hs_idx];
  end

  // scoreboard: captured chain bits versus the expected queue
  logic [0:0] exp_q [$];
  logic [0:0] got_q [$];
  int         en_count;
  logic       mon_clear;

  always @(negedge clk) begin
    if (mon_clear) begin
      got_q.delete();
      en_count = 0;
    end else if (chain_enable) begin
      got_q.push_back(chain_in);
      en_count++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    hs_clear  = 1'b1;
    mon_clear = 1'b1;
    tick();
    tick();
    hs_clear  = 1'b0;
    mon_clear = 1'b0;
  endtask

  // start is sampled at the next edge ("edge 0"); returns in cycle 1
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int c0, output int c);
    c = c0;
    while (!done && !error && c < 300) begin
      tick();
      c++;
    end
  endtask

  task automatic check_seq(input string tag);
    logic [0:0] g;
    check($sformatf("%s enable_count", tag), en_count, CL);
    for (int i = 0; i < CL; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 1'bx;
      check($sformatf("%s bit%0d", tag, i), g, exp_q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [0:CL-1] seq;
    seq = 20'b1010_0101_0011_1100_1001;
    for (int i = 0; i < CL; i++) exp_q.push_back(seq[i]);
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h09;
    words[3] = 8'hC5;

    rst = 1'b1; start = 1'b0; wvalid = 1'b0; chain_out = 1'b0;
    hs_clear = 1'b1; mon_clear = 1'b1;
    repeat (3) tick();
    check("rst nreset", chain_nreset, 1'b0);
    check("rst enable", chain_enable, 1'b0);
    check("rst chain_in", chain_in, 1'b0);
    check("rst ready", word_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst error", error, 1'b0);
    rst = 1'b0; hs_clear = 1'b0; mon_clear = 1'b0;
    tick();
    check("idle nreset", chain_nreset, 1'b0);

    // basic load with word_valid held high
    wvalid = 1'b1;
    do_start();
    check("c1 nreset", chain_nreset, 1'b0);
    check("c1 busy", busy, 1'b1);
    check("c1 ready", word_ready, 1'b0);
    tick();
    check("c2 nreset", chain_nreset, 1'b0);
    check("c2 ready", word_ready, 1'b0);
    tick();
    check("c3 ready", word_ready, 1'b1);
    check("c3 nreset", chain_nreset, 1'b1);
    check("c3 enable", chain_enable, 1'b0);
    tick();
    check("c4 enable", chain_enable, 1'b1);
    check("c4 chain_in", chain_in, 1'b1);
    wait_end(4, c);
    check("t1 done cycle", c, DONE_CYCLE);
    check("t1 done", done, 1'b1);
    check_seq("t1");
    check("t1 words", hs_idx, N_WORDS);
    check("t1 ready", word_ready, 1'b0);
    check("t1 busy", busy, 1'b0);
    check("t1 nreset", chain_nreset, 1'b1);
    repeat (3) tick();
    check("t1 done hold", done, 1'b1);
    check("t1 enable idle", chain_enable, 1'b0);

    // stall word_valid for 5 cycles after the first word; start is ignored there
    clear_sb();
    do_start();
    tick();
    tick();
    tick();
    check("t2 first hs", hs_idx, 1);
    wvalid = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2 stall%0d enable", k), chain_enable, 1'b0);
      check($sformatf("t2 stall%0d ready", k), word_ready, 1'b1);
      start = (k == 1);
      tick();
    end
    start = 1'b0;
    check("t2 still load", word_ready, 1'b1);
    wvalid = 1'b1;
    wait_end(17, c);
    check("t2 done cycle", c, DONE_CYCLE + 5);
    check("t2 done", done, 1'b1);
    check_seq("t2");

    // chain_out forced high on the 7th shift
    clear_sb();
    do_start();
    repeat (9) tick();
    check("t3 7th enable", chain_enable, 1'b1);
    chain_out = 1'b1;
    tick();
    chain_out = 1'b0;
    check("t3 error", error, 1'b1);
    check("t3 nreset", chain_nreset, 1'b0);
    check("t3 enable", chain_enable, 1'b0);
    check("t3 busy", busy, 1'b0);
    check("t3 done", done, 1'b0);
    repeat (10) tick();
    check("t3 enable count", en_count, 7);
    check("t3 error hold", error, 1'b1);
    check("t3 ready", word_ready, 1'b0);

    // reset during the 10th shift, then reload from scratch
    clear_sb();
    do_start();
    repeat (13) tick();
    check("t4 10th enable", chain_enable, 1'b1);
    check("t4 enables before", en_count, 9);
    rst = 1'b1;
    tick();
    check("t4 nreset", chain_nreset, 1'b0);
    check("t4 enable", chain_enable, 1'b0);
    check("t4 chain_in", chain_in, 1'b0);
    check("t4 ready", word_ready, 1'b0);
    check("t4 busy", busy, 1'b0);
    check("t4 done", done, 1'b0);
    check("t4 error", error, 1'b0);
    rst = 1'b0;
    tick();
    clear_sb();
    do_start();
    wait_end(1, c);
    check("t4 done cycle", c, DONE_CYCLE);
    check("t4 done", done, 1'b1);
    check_seq("t4");

`ifdef COLUMN_CONFIG_CRC_EN
    // CRC word with bit 0 inverted
    words[3] = 8'hC4;
    clear_sb();
    do_start();
    wait_end(1, c);
    check("t5 error", error, 1'b1);
    check("t5 done", done, 1'b0);
    check("t5 nreset", chain_nreset, 1'b0);
    check("t5 words", hs_idx, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
